// File: rtl/charli_key_scan.sv
// +----------------------------------------------------------------------------+
// | charli_key_scan: 4-pin charlieplexed 12-key scanner with per-key debounce.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module charli_key_scan #(
  parameter int SETTLE   = 4096,
  parameter int GAP      = 2,
  parameter int DB_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [3:0]  charli_pin,
  output logic [11:0] keys,
  output logic [11:0] chg,
  output logic        key_event,
  output logic        scan_done
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] GAP_LAST    = 16'(GAP - 1);
  localparam logic [3:0]  DB_LIM      = 4'(DB_SCANS);

  typedef enum logic [0:0] {
    S_DRIVE = 1'b0,
    S_GAP   = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  meta_q, sync_q;
  logic [11:0] raw_q, raw_d;
  logic [11:0] keys_q, keys_d;
  logic [11:0] chg_q, chg_d;
  logic        key_event_q, key_event_d;
  logic        scan_done_q, scan_done_d;
  logic [3:0]  db_cnt_q [12];
  logic [3:0]  db_cnt_d [12];
  logic [3:0]  drive_en;

  // Gating with the live reset input releases the pins the same cycle rst drops.
  assign drive_en = (state_q == S_DRIVE && rst) ? (4'b0001 << phase_q) : 4'b0000;

  for (genvar i = 0; i < 4; i++) begin : g_pin
    assign charli_pin[i] = drive_en[i] ? 1'b0 : 1'bz;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q + 16'd1;
    raw_d       = raw_q;
    scan_done_d = 1'b0;
    case (state_q)
      S_DRIVE: begin
        if (cnt_q == SETTLE_LAST) begin
          case (phase_q)
            2'd0: begin raw_d[5]  = ~sync_q[1]; raw_d[9] = ~sync_q[2]; raw_d[11] = ~sync_q[3]; end
            2'd1: begin raw_d[2]  = ~sync_q[0]; raw_d[4] = ~sync_q[2]; raw_d[8]  = ~sync_q[3]; end
            2'd2: begin raw_d[7]  = ~sync_q[0]; raw_d[1] = ~sync_q[1]; raw_d[3]  = ~sync_q[3]; end
            default: begin raw_d[10] = ~sync_q[0]; raw_d[6] = ~sync_q[1]; raw_d[0] = ~sync_q[2]; end
          endcase
          state_d     = S_GAP;
          cnt_d       = 16'd0;
          scan_done_d = (phase_q == 2'd3);
        end
      end
      default: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_DRIVE;
          phase_d = phase_q + 2'd1;
          cnt_d   = 16'd0;
        end
      end
    endcase
  end

  // Debounce is evaluated once per scan, in the scan_done cycle.
  always_comb begin
    keys_d = keys_q;
    for (int k = 0; k < 12; k++) begin
      db_cnt_d[k] = db_cnt_q[k];
      if (scan_done_q) begin
        if (raw_q[k] == keys_q[k]) begin
          db_cnt_d[k] = 4'd0;
        end else if (db_cnt_q[k] + 4'd1 == DB_LIM) begin
          keys_d[k]   = ~keys_q[k];
          db_cnt_d[k] = 4'd0;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 4'd1;
        end
      end
    end
    chg_d       = keys_d ^ keys_q;
    key_event_d = |chg_d;
  end

  always_ff @(posedge clk) begin
    meta_q <= charli_pin;
    sync_q <= meta_q;
    if (!rst) begin
      state_q     <= S_DRIVE;
      phase_q     <= 2'd0;
      cnt_q       <= 16'd0;
      raw_q       <= 12'd0;
      keys_q      <= 12'd0;
      chg_q       <= 12'd0;
      key_event_q <= 1'b0;
      scan_done_q <= 1'b0;
      for (int k = 0; k < 12; k++) begin
        db_cnt_q[k] <= 4'd0;
      end
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      raw_q       <= raw_d;
      keys_q      <= keys_d;
      chg_q       <= chg_d;
      key_event_q <= key_event_d;
      scan_done_q <= scan_done_d;
      for (int k = 0; k < 12; k++) begin
        db_cnt_q[k] <= db_cnt_d[k];
      end
    end
  end

  assign keys      = keys_q;
  assign chg       = chg_q;
  assign key_event = key_event_q;
  assign scan_done = scan_done_q;

endmodule

`default_nettype wire

// File: tb/tb_charli_key_scan.sv
// +----------------------------------------------------------------------------+
// | tb_charli_key_scan: scoreboard bench for charli_key_scan with a diode model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_charli_key_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  wire  [3:0]  charli_pin;
  logic [11:0] keys;
  logic [11:0] chg;
  logic        key_event;
  logic        scan_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [11:0] pressed = 12'h000;
  logic [3:0]  pull_q  = 4'h0;

  // Key k conducts from its drive pin to its sense pin.
  localparam int DRV [12] = '{3, 2, 1, 2, 1, 0, 3, 2, 1, 0, 3, 0};
  localparam int SNS [12] = '{2, 1, 0, 3, 2, 1, 1, 0, 3, 2, 0, 3};

  typedef struct {
    int          cyc;
    logic [11:0] keys;
    logic [11:0] chg;
  } ev_t;

  ev_t exp_q [$];

  always #5 clk = ~clk;

  charli_key_scan #(
    .SETTLE  (8),
    .GAP     (2),
    .DB_SCANS(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .charli_pin(charli_pin),
    .keys      (keys),
    .chg       (chg),
    .key_event (key_event),
    .scan_done (scan_done)
  );

  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup (charli_pin[i]);
    assign charli_pin[i] = pull_q[i] ? 1'b0 : 1'bz;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Diode model: a pressed key pulls its sense pin low while the DUT holds its drive pin low.
  always @(negedge clk) begin
    logic [3:0] dut_low;
    logic [3:0] nxt;
    dut_low = ~charli_pin & ~pull_q;
    nxt     = 4'h0;
    for (int k = 0; k < 12; k++) begin
      if (pressed[k] && dut_low[DRV[k]]) nxt[SNS[k]] = 1'b1;
    end
    pull_q <= nxt;
  end

  // Monitor: pin schedule, scan_done timing and scoreboard pops on key_event.
  always @(negedge clk) begin
    logic [3:0] exp_drv;
    logic [3:0] dut_low;
    int         ph;
    ev_t        e;
    dut_low = ~charli_pin & ~pull_q;
    if (!rst) begin
      chk("pins_in_reset", {28'd0, dut_low}, 32'd0);
    end else begin
      ph      = (cyc % 40) / 10;
      exp_drv = ((cyc % 10) < 8) ? (4'b0001 << ph) : 4'b0000;
      chk("pin_drive", {28'd0, dut_low}, {28'd0, exp_drv});
      chk("scan_done", {31'd0, scan_done}, {31'd0, ((cyc % 40) == 38)});
      if (key_event) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_event: got key_event=1 keys=%h chg=%h at cycle %0d, required no event",
                   keys, chg, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("event_keys", {20'd0, keys}, {20'd0, e.keys});
          chk("event_chg", {20'd0, chg}, {20'd0, e.chg});
        end
      end else begin
        chk("chg_idle", {20'd0, chg}, 32'd0);
      end
    end
  end

  task automatic push_ev(input int c, input logic [11:0] k, input logic [11:0] m);
    ev_t e;
    e.cyc  = c;
    e.keys = k;
    e.chg  = m;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n) begin
      @(posedge clk);
      #2;
      guard++;
      if (guard > 5000) begin
        n_bad++;
        $display("FAIL goto_timeout: got cycle %0d required %0d", cyc, n);
        break;
      end
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_keys", {20'd0, keys}, 32'd0);
    chk("rst_chg", {20'd0, chg}, 32'd0);
    chk("rst_key_event", {31'd0, key_event}, 32'd0);
    chk("rst_scan_done", {31'd0, scan_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200us");
    $fatal(1);
  end

  initial begin
    // Idle scan with no keys pressed.
    pressed = 12'h000;
    do_reset(3);
    chk_reset_state();
    goto(130);
    chk("idle_keys", {20'd0, keys}, 32'd0);

    // k0 held from cycle 0, then a one-scan release glitch, then a real release.
    pressed = 12'h001;
    do_reset(2);
    push_ev(119, 12'h001, 12'h001);
    goto(120);
    pressed = 12'h000;
    goto(160);
    pressed = 12'h001;
    goto(200);
    pressed = 12'h000;
    push_ev(319, 12'h000, 12'h001);
    goto(300);
    chk("k0_still_held", {20'd0, keys}, 32'h001);
    goto(340);
    chk("pending_k0", exp_q.size(), 32'd0);

    // k5+k11 together, then k6+k9 added while held.
    pressed = 12'h820;
    do_reset(2);
    push_ev(119, 12'h820, 12'h820);
    goto(120);
    pressed = 12'ha60;
    push_ev(239, 12'ha60, 12'h240);
    goto(250);
    chk("pending_multi", exp_q.size(), 32'd0);

    // Mid-scan reset while k5 is two scans into its debounce.
    pressed = 12'h020;
    do_reset(2);
    goto(105);
    rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    chk_reset_state();
    push_ev(119, 12'h020, 12'h020);
    goto(100);
    chk("k5_not_yet", {20'd0, keys}, 32'd0);
    goto(130);
    chk("pending_k5", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/charli_key_scan.md
CHARLI_KEY_SCAN -- requirements
Module: charli_key_scan

Interface
REQ-001 Parameter SETTLE, default 4096, sets the number of drive cycles per phase before sampling; legal range 4..65535.
REQ-002 Parameter GAP, default 2, sets the number of all-Z cycles between phases; legal range 1..255.
REQ-003 Parameter DB_SCANS, default 4, sets the number of consecutive full scans that must disagree with the committed state before a key bit changes; legal range 1..15.
REQ-004 Port clk  in  1  is the single clock; all logic is rising-edge.
REQ-005 Port rst  in  1  is the reset: synchronous, active-low.
REQ-006 Port charli_pin  inout  4  is the charlieplexed key matrix; board pull-ups are on all four pins; the block only ever drives 0 or Z, never 1.
REQ-007 Port keys  out  12  is the debounced key state; 1 = pressed.
REQ-008 Port chg  out  12  is the mask of key bits that changed on the current key_event cycle.
REQ-009 Port key_event  out  1  is a one-cycle pulse when keys changes.
REQ-010 Port scan_done  out  1  is a one-cycle pulse at the end of every full 4-phase scan.

Function
REQ-011 Key matrix (drive pin low -> sensed pins:keys) is fixed as follows.
- Phase 0: pin0 low; pin1:k5, pin2:k9, pin3:k11.
- Phase 1: pin1 low; pin0:k2, pin2:k4, pin3:k8.
- Phase 2: pin2 low; pin0:k7, pin1:k1, pin3:k3.
- Phase 3: pin3 low; pin0:k10, pin1:k6, pin2:k0.
REQ-012 A sensed pin reading 0 while its phase pin is driven low SHALL mark the mapped key raw-pressed; the driven pin's own readback SHALL be ignored.
REQ-013 All four charli_pin inputs SHALL pass through a 2-flop synchronizer before use.
REQ-014 The FSM SHALL use the states DRIVE and GAP, plus a 2-bit phase counter and a 16-bit cycle counter.
REQ-015 In DRIVE, only the phase pin SHALL be driven 0 and the other pins SHALL be Z; the FSM stays for SETTLE cycles (count 0..SETTLE-1).
REQ-016 The three sensed bits SHALL be sampled into raw[11:0] on the DRIVE cycle with count == SETTLE-1.
REQ-017 In GAP, all pins SHALL be Z for GAP cycles; the FSM then enters DRIVE with phase+1, wrapping 3->0.
REQ-018 The scan period SHALL be exactly 4*(SETTLE+GAP) cycles.
REQ-019 scan_done SHALL pulse on the first GAP cycle after the phase-3 sample.
REQ-020 Debounce runs in that same cycle, with one 4-bit counter per key:
- If raw[k] == keys[k], the counter clears.
- Otherwise the counter increments.
- When the counter reaches DB_SCANS, keys[k] toggles and the counter clears.
REQ-021 key_event and chg SHALL be registered and asserted in the cycle after scan_done, for exactly one cycle, only if any key toggled.
REQ-022 chg SHALL equal the XOR of the old and new keys values on a key_event cycle and SHALL be 0 at all other times.
REQ-023 Multiple keys toggling in the same scan SHALL produce a single key_event with several chg bits set.
REQ-024 Any number of simultaneous pressed keys SHALL be reported independently; the block performs no ghost suppression.
REQ-025 Debounce counters SHALL saturate logic-free by construction (they clear at DB_SCANS) and SHALL never wrap.

Reset
REQ-026 While rst == 0 at a clk edge, the following SHALL hold on the next cycle:
- all charli_pin outputs are Z;
- FSM = DRIVE, phase = 0, count = 0;
- raw, keys, chg and all debounce counters = 0;
- key_event = 0 and scan_done = 0.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no scan_done pulse and no key_event pulse, and all pins SHALL be Z within one cycle.
REQ-028 After rst returns to 1, the first phase-0 DRIVE cycle SHALL be the first cycle with rst high.

Verification
REQ-029 The bench SHALL use SETTLE=8, GAP=2, DB_SCANS=3, giving a scan period of 40 cycles.
REQ-030 Scenario: release reset with no keys pressed.
- pin0 driven 0 on cycles 0-7 with pins 1-3 Z.
- All pins Z on cycles 8-9.
- pin1 driven on cycles 10-17.
- scan_done pulses at cycle 38, 78, and so on.
- keys stays 0 and key_event never pulses.
REQ-031 Scenario: the model shorts pin2 to a driven-low pin3 (k0) from cycle 0 onward.
- keys[0] = 1 with chg = 12'h001 and key_event = 1 at cycle 119 (the third scan).
- key_event stays 0 at cycles 39 and 79.
REQ-032 Scenario: k0 is pressed and held as in REQ-031, then released.
- The release is followed by exactly 3 scans before keys[0] = 0 with chg = 12'h001.
- A 1-scan release glitch SHALL produce no key_event.
REQ-033 Scenario: k5 and k11 are pressed together (phase-0 pins 1 and 3 low).
- One key_event with chg = 12'h820 and keys = 12'h820.
REQ-034 Scenario: rst is pulsed low for one cycle at cycle 25 of the third scan while k5 is debouncing.
- keys = 0 afterwards and pins are Z for the reset cycle.
- The next phase-0 drive begins on the cycle rst is high.
- k5 requires a full 3 new scans to commit.
REQ-035 Scenario: check every drive phase.
- At no cycle is any pin driven 1.
- At no cycle is more than one pin driven 0.
